// File: rtl/fetch_unit.sv
// Instruction fetch stage in front of a 1-cycle synchronous BRAM.
// Presents one instruction per cycle, holds under decode back-pressure and restarts on redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [31:0]        pcnext,
    input  logic               de_ready,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               if_valid,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_pc4,
    output logic [31:0]        if_instr,
    output logic               misalign
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t       state;
    logic [31:0]  fetch_pc;
    logic [31:0]  out_pc;
    logic [31:0]  skid;
    logic         bubble;
    logic         mis_q;
    logic [31:0]  redirect_pc;
    logic         issue_en;
    logic [IMEM_AW-1:0] issue_addr;

    assign redirect_pc = {pcnext[31:2], 2'b00};

    // The bubble cycle after a redirect re-issues the target so it is presented one cycle later.
    always_comb begin
        issue_en   = 1'b0;
        issue_addr = fetch_pc[IMEM_AW+1:2];
        if (rst) begin
            issue_en = 1'b0;
        end else if (redirect) begin
            issue_en   = 1'b1;
            issue_addr = pcnext[IMEM_AW+1:2];
        end else begin
            case (state)
                BOOT: issue_en = 1'b1;
                RUN: begin
                    if (bubble) begin
                        issue_en   = 1'b1;
                        issue_addr = out_pc[IMEM_AW+1:2];
                    end else begin
                        issue_en = de_ready;
                    end
                end
                HOLD:    issue_en = de_ready;
                default: issue_en = 1'b0;
            endcase
        end
    end

    assign imem_en   = issue_en;
    assign imem_addr = issue_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BOOT;
            fetch_pc <= RESET_PC;
            out_pc   <= RESET_PC;
            skid     <= 32'h0;
            bubble   <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            mis_q <= redirect && (pcnext[1:0] != 2'b00);
            if (redirect) begin
                state    <= RUN;
                out_pc   <= redirect_pc;
                fetch_pc <= redirect_pc + 32'd4;
                skid     <= 32'h0;
                bubble   <= 1'b1;
            end else begin
                case (state)
                    BOOT: begin
                        out_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + 32'd4;
                        bubble   <= 1'b0;
                        state    <= RUN;
                    end
                    RUN: begin
                        if (bubble) begin
                            bubble <= 1'b0;
                        end else if (de_ready) begin
                            out_pc   <= fetch_pc;
                            fetch_pc <= fetch_pc + 32'd4;
                        end else begin
                            skid  <= imem_rdata;
                            state <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (de_ready) begin
                            out_pc   <= fetch_pc;
                            fetch_pc <= fetch_pc + 32'd4;
                            state    <= RUN;
                        end
                    end
                    default: state <= BOOT;
                endcase
            end
        end
    end

    always_comb begin
        if_instr = 32'h0;
        if (!rst) begin
            if (state == HOLD) begin
                if_instr = skid;
            end else if (state == RUN && !bubble) begin
                if_instr = imem_rdata;
            end
        end
    end

    assign if_valid = !rst && ((state == RUN && !bubble) || state == HOLD);
    assign if_pc    = rst ? RESET_PC : out_pc;
    assign if_pc4   = if_pc + 32'd4;
    assign misalign = mis_q && !rst;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, a wrap-around sequence, then random traffic
// checked against a stream-level model of the fetch behaviour.
module tb_fetch_unit;

    localparam int          IMEM_AW  = 14;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          NVEC     = 17;
    localparam int          NRAND    = 3000;

    logic               clk;
    logic               rst;
    logic               redirect;
    logic [31:0]        pcnext;
    logic               de_ready;
    logic               imem_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic               if_valid;
    logic [31:0]        if_pc;
    logic [31:0]        if_pc4;
    logic [31:0]        if_instr;
    logic               misalign;

    int checks;
    int errors;
    logic [31:0] exp_q[$];

    fetch_unit #(.RESET_PC(RESET_PC), .IMEM_AW(IMEM_AW)) dut (
        .clk(clk),
        .rst(rst),
        .redirect(redirect),
        .pcnext(pcnext),
        .de_ready(de_ready),
        .imem_en(imem_en),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .if_valid(if_valid),
        .if_pc(if_pc),
        .if_pc4(if_pc4),
        .if_instr(if_instr),
        .misalign(misalign)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // BRAM model: word n holds the value n.
    initial imem_rdata = 32'h0;
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= {{(32-IMEM_AW){1'b0}}, imem_addr};
    end

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        logic [31:0] w;
        w = pc >> 2;
        w = w & ((32'h1 << IMEM_AW) - 32'h1);
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic red, input logic [31:0] pn, input logic de);
        rst      = r;
        redirect = red;
        pcnext   = pn;
        de_ready = de;
    endtask

    typedef struct {
        logic        rst;
        logic        redirect;
        logic [31:0] pcnext;
        logic        de_ready;
        logic        exp_valid;
        logic        chk_pc;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic        exp_mis;
        logic [1:0]  exp_en;   // 2 = not checked
    } vec_t;

    vec_t vecs[NVEC];

    task automatic set_vec(input int i, input logic r, input logic red, input logic [31:0] pn,
                           input logic de, input logic v, input logic cp, input logic [31:0] pc,
                           input logic [31:0] ins, input logic mis, input logic [1:0] en);
        vecs[i].rst       = r;
        vecs[i].redirect  = red;
        vecs[i].pcnext    = pn;
        vecs[i].de_ready  = de;
        vecs[i].exp_valid = v;
        vecs[i].chk_pc    = cp;
        vecs[i].exp_pc    = pc;
        vecs[i].exp_instr = ins;
        vecs[i].exp_mis   = mis;
        vecs[i].exp_en    = en;
    endtask

    // model state for the random phase
    logic [31:0] m_pc;
    int          m_wait;
    logic        m_mis;

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b1, 1'b0, 32'h0, 1'b1);

        //          i  rst red pcnext    de  v  cpc pc        instr  mis en
        set_vec( 0, 1, 0, 32'h0,    1, 0, 1, 32'h00, 32'd0,  0, 2'd0);
        set_vec( 1, 0, 0, 32'h0,    1, 0, 1, 32'h00, 32'd0,  0, 2'd1);
        set_vec( 2, 0, 0, 32'h0,    1, 1, 1, 32'h00, 32'd0,  0, 2'd1);
        set_vec( 3, 0, 0, 32'h0,    1, 1, 1, 32'h04, 32'd1,  0, 2'd1);
        set_vec( 4, 0, 0, 32'h0,    0, 1, 1, 32'h08, 32'd2,  0, 2'd0);
        set_vec( 5, 0, 0, 32'h0,    0, 1, 1, 32'h08, 32'd2,  0, 2'd0);
        set_vec( 6, 0, 0, 32'h0,    0, 1, 1, 32'h08, 32'd2,  0, 2'd0);
        set_vec( 7, 0, 0, 32'h0,    1, 1, 1, 32'h08, 32'd2,  0, 2'd1);
        set_vec( 8, 0, 1, 32'h42,   1, 1, 1, 32'h0C, 32'd3,  0, 2'd1);
        set_vec( 9, 0, 0, 32'h0,    1, 0, 0, 32'h00, 32'd0,  1, 2'd2);
        set_vec(10, 0, 0, 32'h0,    0, 1, 1, 32'h40, 32'd16, 0, 2'd0);
        set_vec(11, 0, 1, 32'h80,   0, 1, 1, 32'h40, 32'd16, 0, 2'd1);
        set_vec(12, 0, 0, 32'h0,    0, 0, 0, 32'h00, 32'd0,  0, 2'd2);
        set_vec(13, 1, 1, 32'h100,  1, 0, 1, 32'h00, 32'd0,  0, 2'd0);
        set_vec(14, 0, 0, 32'h0,    1, 0, 1, 32'h00, 32'd0,  0, 2'd1);
        set_vec(15, 0, 0, 32'h0,    1, 1, 1, 32'h00, 32'd0,  0, 2'd1);
        set_vec(16, 0, 0, 32'h0,    1, 1, 1, 32'h04, 32'd1,  0, 2'd1);

        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].redirect, vecs[i].pcnext, vecs[i].de_ready);
            #1;
            check($sformatf("vec%0d if_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].exp_valid});
            check($sformatf("vec%0d misalign", i), {31'b0, misalign}, {31'b0, vecs[i].exp_mis});
            if (vecs[i].exp_en != 2'd2)
                check($sformatf("vec%0d imem_en", i), {31'b0, imem_en}, {31'b0, vecs[i].exp_en[0]});
            if (vecs[i].chk_pc) begin
                check($sformatf("vec%0d if_pc", i), if_pc, vecs[i].exp_pc);
                check($sformatf("vec%0d if_pc4", i), if_pc4, vecs[i].exp_pc + 32'd4);
            end
            if (vecs[i].exp_valid || vecs[i].rst)
                check($sformatf("vec%0d if_instr", i), if_instr, vecs[i].exp_instr);
        end

        // wrap-around through the top of the address space, misaligned target
        @(negedge clk);
        drive(1'b0, 1'b1, 32'hFFFF_FFF9, 1'b1);
        #1;
        check("wrap issue_en", {31'b0, imem_en}, 32'd1);
        check("wrap issue_addr", {18'b0, imem_addr}, word_at(32'hFFFF_FFF8));
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        check("wrap bubble_valid", {31'b0, if_valid}, 32'd0);
        check("wrap misalign", {31'b0, misalign}, 32'd1);
        @(negedge clk);
        #1;
        check("wrap misalign_clear", {31'b0, misalign}, 32'd0);
        check("wrap pc0", if_pc, 32'hFFFF_FFF8);
        check("wrap instr0", if_instr, word_at(32'hFFFF_FFF8));
        @(negedge clk);
        #1;
        check("wrap pc1", if_pc, 32'hFFFF_FFFC);
        check("wrap pc4_1", if_pc4, 32'h0000_0000);
        check("wrap instr1", if_instr, word_at(32'hFFFF_FFFC));
        @(negedge clk);
        #1;
        check("wrap pc2", if_pc, 32'h0000_0000);
        check("wrap instr2", if_instr, 32'd0);

        // random traffic against the stream model
        m_pc   = RESET_PC;
        m_wait = 1;
        m_mis  = 1'b0;
        for (int c = 0; c < NRAND; c++) begin
            logic        r;
            logic        red;
            logic [31:0] pn;
            logic        de;
            logic        m_valid;
            r   = (c == 0) || ($urandom_range(0, 63) == 0);
            red = ($urandom_range(0, 7) == 0);
            pn  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
            de  = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            drive(r, red, pn, de);
            #1;
            if (r) begin
                m_valid = 1'b0;
                check("rnd rst_valid", {31'b0, if_valid}, 32'd0);
                check("rnd rst_pc", if_pc, RESET_PC);
                check("rnd rst_instr", if_instr, 32'd0);
                check("rnd rst_en", {31'b0, imem_en}, 32'd0);
                check("rnd rst_mis", {31'b0, misalign}, 32'd0);
            end else begin
                m_valid = (m_wait == 0);
                check("rnd valid", {31'b0, if_valid}, {31'b0, m_valid});
                check("rnd misalign", {31'b0, misalign}, {31'b0, m_mis});
                if (m_valid) begin
                    check("rnd pc", if_pc, m_pc);
                    check("rnd pc4", if_pc4, m_pc + 32'd4);
                    check("rnd instr", if_instr, word_at(m_pc));
                end
                if (m_valid && de) exp_q.push_back(word_at(m_pc));
                if (if_valid && de) begin
                    if (exp_q.size() == 0) begin
                        checks = checks + 1;
                        errors = errors + 1;
                        $display("FAIL rnd accept actual=%h expected=none at %0t", if_instr, $time);
                    end else begin
                        check("rnd accept", if_instr, exp_q.pop_front());
                    end
                end
            end
            // advance the model
            m_mis = !r && red && (pn[1:0] != 2'b00);
            if (r) begin
                m_pc   = RESET_PC;
                m_wait = 1;
            end else if (red) begin
                m_pc   = {pn[31:2], 2'b00};
                m_wait = 1;
            end else if (m_wait > 0) begin
                m_wait = m_wait - 1;
            end else if (de) begin
                m_pc = m_pc + 32'd4;
            end
        end
        check("rnd accept_drain", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
